// File: rtl/dfi_log_walker.sv
// dfi_log_walker: walks the instrumented store/load log and flags loads whose last writer is not an allowed DFG pair.
// Optional DFI_MISS_IS_VIOL_EN: a load that misses the shadow table is also a violation.
module dfi_log_walker #(
    parameter int N_ADDR_WIDTH = 32,
    parameter int N_DATA_WIDTH = 32,
    parameter int N_LOGID_WIDTH = 8,
    parameter int N_DFG_LINES = 10,
    parameter int N_SHADOW = 8,
    parameter int LOG_STRIDE = 8,
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFFC00,
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND = 32'h1FEFFFF8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_trigger,
    input  logic [N_ADDR_WIDTH-1:0]               i_logAddrptr,
    input  logic                                  i_logDone,
    input  logic [N_LOGID_WIDTH+N_DATA_WIDTH-1:0] i_logData,
    input  logic                                  i_cfgWe,
    input  logic [$clog2(N_DFG_LINES)-1:0]        i_cfgLine,
    input  logic [2*N_LOGID_WIDTH:0]              i_cfgPair,
    output logic                                  o_rqAccess,
    output logic [N_ADDR_WIDTH-1:0]               o_logAddr,
    output logic                                  o_invWrite,
    output logic [N_LOGID_WIDTH-1:0]              o_violId,
    output logic [N_DATA_WIDTH-1:0]               o_violAddr,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_timeout
);
    localparam int LINE_W = $clog2(N_DFG_LINES);
    localparam int SH_W = (N_SHADOW > 1) ? $clog2(N_SHADOW) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [N_ADDR_WIDTH-1:0] STRIDE = N_ADDR_WIDTH'(LOG_STRIDE);
    localparam logic [N_ADDR_WIDTH-1:0] END_MAX = LOGTABLE_ADDREND + STRIDE;
`ifdef DFI_MISS_IS_VIOL_EN
    localparam logic MISS_VIOL = 1'b1;
`else
    localparam logic MISS_VIOL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, FIN} stateT;
    stateT state, stateNext;

    logic [N_ADDR_WIDTH-1:0]  endAddr, nextAddr, trigEnd;
    logic [N_LOGID_WIDTH-1:0] curId;
    logic [N_DATA_WIDTH-1:0]  curAddr;
    logic [TMO_W-1:0]         tmoCnt;
    logic                     tmoHit;

    logic [N_SHADOW-1:0]      shValid;
    logic [N_DATA_WIDTH-1:0]  shAddr [N_SHADOW];
    logic [N_LOGID_WIDTH-1:0] shWriter [N_SHADOW];
    logic [SH_W-1:0]          rrPtr, hitIdx, freeIdx, fillIdx;
    logic                     hit, freeFound, legal, isLoad, viol;

    logic [N_DFG_LINES-1:0]   dfgValid;
    logic [N_LOGID_WIDTH-1:0] dfgLoad [N_DFG_LINES];
    logic [N_LOGID_WIDTH-1:0] dfgStore [N_DFG_LINES];

    assign trigEnd = (i_logAddrptr < END_MAX) ? i_logAddrptr : END_MAX;
    assign nextAddr = o_logAddr + STRIDE;
    assign tmoHit = tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1);
    assign isLoad = curId[N_LOGID_WIDTH-1];

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit = 1'b0;
        hitIdx = '0;
        freeFound = 1'b0;
        freeIdx = '0;
        for (int i = N_SHADOW - 1; i >= 0; i--) begin
            if (shValid[i] && shAddr[i] == curAddr) begin
                hit = 1'b1;
                hitIdx = SH_W'(i);
            end
            if (!shValid[i]) begin
                freeFound = 1'b1;
                freeIdx = SH_W'(i);
            end
        end
        legal = 1'b0;
        for (int i = 0; i < N_DFG_LINES; i++)
            legal = legal | (dfgValid[i] && dfgLoad[i] == curId && dfgStore[i] == shWriter[hitIdx]);
        fillIdx = hit ? hitIdx : freeFound ? freeIdx : rrPtr;
        viol = isLoad && (hit ? !legal : MISS_VIOL);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (i_trigger) stateNext = (trigEnd <= LOGTABLE_ADDRINIT) ? FIN : WAIT;
            WAIT:  stateNext = i_logDone ? CHECK : tmoHit ? FIN : WAIT;
            CHECK: stateNext = (nextAddr >= endAddr) ? FIN : WAIT;
            FIN:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= stateNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rqAccess <= 1'b0;
            o_logAddr <= '0;
            o_invWrite <= 1'b0;
            o_violId <= '0;
            o_violAddr <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_timeout <= 1'b0;
            endAddr <= '0;
            curId <= '0;
            curAddr <= '0;
            tmoCnt <= '0;
            shValid <= '0;
            rrPtr <= '0;
            dfgValid <= '0;
            for (int i = 0; i < N_SHADOW; i++) begin
                shAddr[i] <= '0;
                shWriter[i] <= '0;
            end
            for (int i = 0; i < N_DFG_LINES; i++) begin
                dfgLoad[i] <= '0;
                dfgStore[i] <= '0;
            end
        end else begin
            o_invWrite <= 1'b0;
            o_done <= 1'b0;
            if (i_cfgWe && i_cfgLine < LINE_W'(N_DFG_LINES)) begin
                dfgValid[i_cfgLine] <= i_cfgPair[2*N_LOGID_WIDTH];
                dfgLoad[i_cfgLine] <= i_cfgPair[2*N_LOGID_WIDTH-1:N_LOGID_WIDTH];
                dfgStore[i_cfgLine] <= i_cfgPair[N_LOGID_WIDTH-1:0];
            end
            case (state)
                IDLE: if (i_trigger) begin
                    endAddr <= trigEnd;
                    if (trigEnd > LOGTABLE_ADDRINIT) begin
                        o_logAddr <= LOGTABLE_ADDRINIT;
                        o_rqAccess <= 1'b1;
                        o_busy <= 1'b1;
                        tmoCnt <= '0;
                    end
                end
                WAIT: if (i_logDone) begin
                    {curId, curAddr} <= i_logData;
                    o_rqAccess <= 1'b0;
                end else if (tmoHit) begin
                    o_timeout <= 1'b1;
                    o_rqAccess <= 1'b0;
                end else tmoCnt <= tmoCnt + 1'b1;
                CHECK: begin
                    if (!isLoad) begin
                        shValid[fillIdx] <= 1'b1;
                        shAddr[fillIdx] <= curAddr;
                        shWriter[fillIdx] <= curId;
                        if (!hit && !freeFound)
                            rrPtr <= (rrPtr == SH_W'(N_SHADOW - 1)) ? '0 : rrPtr + 1'b1;
                    end
                    if (viol) begin
                        o_invWrite <= 1'b1;
                        o_violId <= curId;
                        o_violAddr <= curAddr;
                    end
                    if (nextAddr < endAddr) begin
                        o_logAddr <= nextAddr;
                        o_rqAccess <= 1'b1;
                        tmoCnt <= '0;
                    end
                end
                FIN: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dfi_log_walker.sv
// tb_dfi_log_walker: directed checks of the log walker against a small behavioural log memory.
module tb_dfi_log_walker;
    localparam logic [31:0] INIT = 32'h1FEFFC00;
`ifdef DFI_MISS_IS_VIOL_EN
    localparam int MISS_VIOLS = 1;
`else
    localparam int MISS_VIOLS = 0;
`endif

    logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, logDone = 1'b0, cfgWe = 1'b0;
    logic [31:0] logAddrptr = '0;
    logic [39:0] logData = '0;
    logic [3:0]  cfgLine = '0;
    logic [16:0] cfgPair = '0;
    logic        rqAccess, invWrite, busy, done, timeout;
    logic [31:0] logAddr, violAddr;
    logic [7:0]  violId;

    int tests = 0, errors = 0;
    int invCount = 0, doneCount = 0, rqCycles = 0;
    int inv0, done0, rq0, req0;
    bit respEn = 1'b1;
    logic [31:0] reqLog [$];
    logic [39:0] mem [logic [31:0]];

    dfi_log_walker dut (
        .clk(clk), .rst(rst), .i_trigger(trigger), .i_logAddrptr(logAddrptr),
        .i_logDone(logDone), .i_logData(logData), .i_cfgWe(cfgWe), .i_cfgLine(cfgLine),
        .i_cfgPair(cfgPair), .o_rqAccess(rqAccess), .o_logAddr(logAddr),
        .o_invWrite(invWrite), .o_violId(violId), .o_violAddr(violAddr),
        .o_busy(busy), .o_done(done), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    // Log memory responder plus event counters, all sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (invWrite) invCount++;
            if (done) doneCount++;
            if (rqAccess) rqCycles++;
            if (respEn && rqAccess && !logDone) begin
                logDone = 1'b1;
                logData = mem.exists(logAddr) ? mem[logAddr] : {8'h00, logAddr};
                reqLog.push_back(logAddr);
            end else logDone = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] line, input logic [16:0] pair);
        @(negedge clk);
        cfgWe = 1'b1;
        cfgLine = line;
        cfgPair = pair;
        @(negedge clk);
        cfgWe = 1'b0;
    endtask

    task automatic snap();
        inv0 = invCount;
        done0 = doneCount;
        rq0 = rqCycles;
        req0 = reqLog.size();
    endtask

    task automatic runWalk(input string tag, input logic [31:0] ptr, input int budget);
        int base = doneCount;
        @(negedge clk);
        logAddrptr = ptr;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        for (int i = 0; i < budget && doneCount == base; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_done"}, 64'(doneCount - base), 64'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("rst_rq", 64'(rqAccess), 64'd0);
        check("rst_addr", 64'(logAddr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_inv", 64'(invWrite), 64'd0);
        check("rst_tmo", 64'(timeout), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Legal store->load pair
        cfg(4'd0, {1'b1, 8'h83, 8'h03});
        mem[INIT] = {8'h03, 32'h40};
        mem[INIT + 8] = {8'h83, 32'h40};
        snap();
        runWalk("legal", INIT + 32'h10, 200);
        check("legal_nreq", 64'(reqLog.size() - req0), 64'd2);
        check("legal_req0", 64'(reqLog[req0]), 64'(INIT));
        check("legal_req1", 64'(reqLog[req0 + 1]), 64'(INIT + 8));
        check("legal_inv", 64'(invCount - inv0), 64'd0);
        check("legal_busy", 64'(busy), 64'd0);

        // Load ID with no DFG line
        mem[INIT + 8] = {8'h84, 32'h40};
        snap();
        runWalk("illegal", INIT + 32'h10, 200);
        check("illegal_inv", 64'(invCount - inv0), 64'd1);
        check("illegal_id", 64'(violId), 64'h84);
        check("illegal_addr", 64'(violAddr), 64'h40);

        // Empty table: FIN right after trigger, done one cycle later
        snap();
        @(negedge clk);
        logAddrptr = INIT;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        #1;
        check("empty_early", 64'(done), 64'd0);
        @(negedge clk);
        #1;
        check("empty_done", 64'(done), 64'd1);
        check("empty_rq", 64'(rqCycles - rq0), 64'd0);
        check("empty_busy", 64'(busy), 64'd0);

        // End clamping
        mem.delete();
        snap();
        runWalk("clamp", 32'h1FF00100, 1000);
        check("clamp_nreq", 64'(reqLog.size() - req0), 64'd128);
        check("clamp_last", 64'(reqLog[reqLog.size() - 1]), 64'h1FEFFFF8);

        // Shadow eviction: 9 stores then loads of the evicted and a resident address
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cfg(4'd0, {1'b1, 8'h85, 8'h05});
        mem.delete();
        for (int i = 0; i < 9; i++) mem[INIT + 32'(8 * i)] = {8'h05, 32'h100 + 32'(4 * i)};
        mem[INIT + 32'h48] = {8'h85, 32'h100};
        mem[INIT + 32'h50] = {8'h85, 32'h104};
        snap();
        runWalk("evict", INIT + 32'h58, 400);
        check("evict_inv", 64'(invCount - inv0), 64'(MISS_VIOLS));

        // Timeout with no read response
        respEn = 1'b0;
        snap();
        runWalk("tmo", INIT + 32'h10, 200);
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_rq", 64'(rqAccess), 64'd0);
        check("tmo_cycles", 64'(rqCycles - rq0), 64'd64);

        // Reset in the middle of WAIT
        snap();
        @(negedge clk);
        logAddrptr = INIT + 32'h10;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_rq", 64'(rqAccess), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_addr", 64'(logAddr), 64'd0);
        check("arst_tmo", 64'(timeout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        respEn = 1'b1;
        check("arst_nodone", 64'(doneCount - done0), 64'd0);
        snap();
        runWalk("restart", INIT + 32'h10, 200);
        check("restart_req0", 64'(reqLog[req0]), 64'(INIT));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
